// File: rtl/painel_varredura_colunas.sv
// Column-scan controller for a 7x5 LED dot-matrix panel: steps the 3-to-7 column decoder,
// blanks at every column change and shows a double-buffered frame swapped only at frame end.
module painel_varredura_colunas #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 50,
  parameter int unsigned DIV_WIDTH    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       swap_req,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       dec_enable,
  output logic [4:0] row,
  output logic       frame_done,
  output logic       swap_ack,
  output logic       swap_pending
);

  localparam logic [DIV_WIDTH-1:0] LastCnt  = DIV_WIDTH'(SCAN_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] BlankCnt = DIV_WIDTH'(BLANK_CYCLES);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           col_q, col_d;
  logic [4:0]           front_q [7];
  logic [4:0]           back_q  [7];
  logic [4:0]           front_d [7];
  logic [4:0]           back_d  [7];
  logic [4:0]           back_w  [7];
  logic [4:0]           row_q, row_d;
  logic                 pending_q, pending_d;
  logic                 dec_q, fd_q, ack_q;
  logic                 frame_end, do_swap, load_col;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    frame_end = 1'b0;
    load_col  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d  = StBlank;
          cnt_d    = '0;
          col_d    = '0;
          load_col = 1'b1;
        end
      end
      StBlank, StShow: begin
        if (!run) begin
          state_d = StIdle;
          cnt_d   = '0;
          col_d   = '0;
        end else if (cnt_q == LastCnt) begin
          state_d   = StBlank;
          cnt_d     = '0;
          col_d     = (col_q == 3'd6) ? 3'd0 : col_q + 3'd1;
          frame_end = (col_q == 3'd6);
          load_col  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d >= BlankCnt) state_d = StShow;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A request arriving on the frame-end cycle is honoured at that same edge.
  assign do_swap   = frame_end && (pending_q || swap_req);
  assign pending_d = (pending_q || swap_req) && !do_swap;

  // The write is merged into the back buffer before the swap, so it becomes visible.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      back_w[i]  = (wr_en && (wr_addr == 3'(i))) ? wr_data : back_q[i];
      front_d[i] = do_swap ? back_w[i] : front_q[i];
      back_d[i]  = do_swap ? front_q[i] : back_w[i];
    end
  end

  always_comb begin
    row_d = row_q;
    if (state_d == StIdle) begin
      row_d = '0;
    end else if (load_col) begin
      for (int i = 0; i < 7; i++) begin
        if (col_d == 3'(i)) row_d = front_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      pending_q <= 1'b0;
      dec_q     <= 1'b0;
      fd_q      <= 1'b0;
      ack_q     <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        front_q[i] <= '0;
        back_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pending_q <= pending_d;
      dec_q     <= (state_d == StShow);
      fd_q      <= frame_end;
      ack_q     <= do_swap;
      front_q   <= front_d;
      back_q    <= back_d;
    end
  end

  assign sel1         = col_q[2];
  assign sel2         = col_q[1];
  assign sel3         = col_q[0];
  assign dec_enable   = dec_q;
  assign row          = row_q;
  assign frame_done   = fd_q;
  assign swap_ack     = ack_q;
  assign swap_pending = pending_q;

endmodule

// File: doc/painel_varredura_colunas.md
Name: painel_varredura_colunas

Overview:
- Column-scan controller for the 7-column x 5-row LED dot-matrix panel.
- Drives the 3-to-7 column decoder: sel1..sel3 select lines plus its enable. Supplies the active-high row pattern for the selected column.
- Holds a double-buffered frame: the host writes the back buffer and requests a swap. The swap is applied only at a frame boundary, so the display never shows a torn image.
- Inserts a blanking interval at every column change to suppress ghosting.

Parameters:
- SCAN_DIV, 1000, clock cycles per column dwell (>=2)
- BLANK_CYCLES, 50, leading cycles of each dwell with decoder disabled (1 <= BLANK_CYCLES < SCAN_DIV)
- DIV_WIDTH, 10, counter width; must satisfy 2^DIV_WIDTH >= SCAN_DIV

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  1 = scan active, 0 = panel dark
- wr_en  in  1  write strobe to back buffer
- wr_addr  in  3  column address 0..6; 7 is ignored
- wr_data  in  5  row pattern for that column, bit0 = top row
- swap_req  in  1  request front/back swap at next frame end
- sel1  out  1  decoder select MSB (column bit 2)
- sel2  out  1  decoder select (column bit 1)
- sel3  out  1  decoder select LSB (column bit 0)
- dec_enable  out  1  decoder enable, 1 = selected column driven
- row  out  5  row pattern of the current column from the front buffer
- frame_done  out  1  1-cycle pulse when column 6 dwell ends
- swap_ack  out  1  1-cycle pulse when a swap is applied
- swap_pending  out  1  swap requested, not yet applied

Behaviour:
- All outputs are registered. Reset (synchronous, priority over all inputs):
  - sel=000, dec_enable=0, row=0, frame_done=0, swap_ack=0, swap_pending=0
  - column=0, dwell counter=0, both buffers cleared to 0, state=IDLE
- States:
  - IDLE
  - BLANK (dwell counter < BLANK_CYCLES, dec_enable=0)
  - SHOW (counter >= BLANK_CYCLES, dec_enable=1)
- IDLE:
  - Outputs sel=000, dec_enable=0, row=0, counter=0, column=0.
  - run=1 -> BLANK at the next edge with column 0.
- Dwell:
  - The counter increments every cycle from 0 to SCAN_DIV-1.
  - BLANK -> SHOW when the counter reaches BLANK_CYCLES.
  - At counter SCAN_DIV-1: counter->0, column->column+1 (6 wraps to 0), state->BLANK.
  - Dwell length is exactly SCAN_DIV cycles. A full frame is 7*SCAN_DIV cycles.
- sel and row update together on the first BLANK cycle of each column.
  - row = front[column], captured at that edge and held for the whole dwell.
  - sel = column in binary; column never reaches 7.
- Frame end (last cycle of column 6 dwell):
  - frame_done=1 in the following cycle.
  - If swap_pending=1: front and back swap on the same edge, swap_ack=1 in the following cycle, swap_pending clears.
  - The first BLANK of column 0 shows the new front.
- swap_req:
  - Sets swap_pending on the next edge.
  - Repeated swap_req while pending has no effect.
  - swap_req in the same cycle as a frame end is applied at that frame end.
  - swap_req in IDLE stays pending until a frame completes.
- Writes:
  - wr_en=1 with wr_addr<=6 writes wr_data to back[wr_addr] at the edge.
  - wr_addr=7 is ignored.
  - A write on the swap edge lands in the pre-swap back buffer, which becomes the new front and is visible.
  - Writes never alter the front buffer directly.
- run deasserted mid-frame:
  - Next edge -> IDLE, dec_enable=0, row=0, sel=000, counter and column reset.
  - No frame_done pulse. swap_pending and buffer contents are retained.
  - Re-asserting run restarts at column 0 BLANK.
- dec_enable is never 1 during a column or row transition edge, so at most one column is lit at any time.

Test Plan:
- SCAN_DIV=4, BLANK_CYCLES=1; reset, run=1 -> sel steps 0,1,...,6,0 every 4 cycles; dec_enable pattern per dwell 0,1,1,1; frame_done pulses once every 28 cycles.
- Write back[0]=5'b10101, back[6]=5'b11111, pulse swap_req mid-frame -> swap_pending=1, row stays 0 until frame end; swap_ack pulse; next frame column 0 row=10101, column 6 row=11111.
- Write with wr_addr=7, wr_data=5'b11111, then swap -> all columns show row=0.
- swap_req asserted on the last cycle of column 6 together with wr_en to column 0 -> swap applied at that edge; column 0 shows the written data in the immediately following frame.
- Drop run during column 3 SHOW -> next cycle dec_enable=0, sel=000, row=0, no frame_done; raise run -> restart at column 0 with counter 0.
- Assert reset during SHOW with swap_pending=1 -> next cycle all outputs 0, swap_pending=0, buffers 0; reset held with run=1 keeps the block in IDLE.
